// File: rtl/bcd_add_sequencer.sv
// Multi-digit BCD adder that reuses one single-digit stage, one digit per clock, LSD first.
// Optional operand digit checking is enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_add_sequencer #(
    parameter int DIGITS = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a_bcd,
    input  logic [4*DIGITS-1:0]   b_bcd,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum_bcd,
    output logic                  cout,
    output logic                  err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One decimal digit stage: returns {carry_out, digit}; raw of exactly 10 must carry.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] a_dig,
                                                 input logic [3:0] b_dig,
                                                 input logic       c_in);
        logic [4:0] raw;
        logic [4:0] adj;
        raw = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, c_in};
        adj = raw - 5'd10;
        if (raw > 5'd9) begin
            bcd_digit_add = {1'b1, adj[3:0]};
        end else begin
            bcd_digit_add = {1'b0, raw[3:0]};
        end
    endfunction

    state_t           state_r, state_s;
    logic [W-1:0]     a_r, a_s;
    logic [W-1:0]     b_r, b_s;
    logic             carry_r, carry_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic [W-1:0]     sum_r, sum_s;
    logic             cout_r, cout_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic [3:0]       a_dig_s;
    logic [3:0]       b_dig_s;
    logic [4:0]       digit_res_s;

    // Next-state, datapath update and registered-output preparation.
    always_comb begin
        state_s     = state_r;
        a_s         = a_r;
        b_s         = b_r;
        carry_s     = carry_r;
        idx_s       = idx_r;
        sum_s       = sum_r;
        cout_s      = cout_r;
        a_dig_s     = a_r[4*idx_r +: 4];
        b_dig_s     = b_r[4*idx_r +: 4];
        digit_res_s = bcd_digit_add(a_dig_s, b_dig_s, carry_r);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    a_s     = a_bcd;
                    b_s     = b_bcd;
                    carry_s = cin;
                    sum_s   = {W{1'b0}};
                    cout_s  = 1'b0;
                    idx_s   = {IDX_W{1'b0}};
                    state_s = ST_ADD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADD: begin
                sum_s[4*idx_r +: 4] = digit_res_s[3:0];
                carry_s             = digit_res_s[4];
                idx_s               = idx_r + IDX_ONE;
                if (idx_r == LAST_IDX) begin
                    cout_s  = digit_res_s[4];
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ADD;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r <= ST_IDLE;
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            carry_r <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
            sum_r   <= {W{1'b0}};
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            a_r     <= a_s;
            b_r     <= b_s;
            carry_r <= carry_s;
            idx_r   <= idx_s;
            sum_r   <= sum_s;
            cout_r  <= cout_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic err_r, err_s;

    // Sticky flag for non-decimal operand digits, cleared on each accepted start.
    always_comb begin
        err_s = err_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    err_s = 1'b0;
                end else begin
                    err_s = err_r;
                end
            end
            ST_ADD: begin
                err_s = err_r | (a_dig_s > 4'd9) | (b_dig_s > 4'd9);
            end
            default: begin
                err_s = err_r;
            end
        endcase
    end

    // Error flag register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_s;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign busy    = busy_r;
    assign done    = done_r;
    assign sum_bcd = sum_r;
    assign cout    = cout_r;

endmodule
